// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one downstream memory port between an instruction
// requester and a data requester. Exactly one downstream transaction is in
// flight at a time (IDLE -> [ADDR] -> DATA -> IDLE). Data normally wins, but
// after STARVE_LIMIT consecutive data grants with inst waiting, inst wins.
// Request valid and address handshakes pass through combinationally so an
// accepted request costs no extra cycle; responses are steered to the owner.

module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [70:0] inst_req_bus,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [70:0] data_req_bus,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic [70:0] mem_req_bus,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    // Counter must be able to hold STARVE_LIMIT itself; keep at least one bit.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Requester index: 0 = inst, 1 = data.
    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state_reg,      state_next;
    logic             owner_reg,      owner_next;
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

    // Requesters gathered into indexable form so steering is uniform.
    logic [NREQ-1:0] req_vec;
    logic [70:0]     req_bus_arr [NREQ];

    assign req_vec[0]     = inst_req;
    assign req_vec[1]     = data_req;
    assign req_bus_arr[0] = inst_req_bus;
    assign req_bus_arr[1] = data_req_bus;

    // Inst wins when it has been starved long enough, or when data is idle.
    logic starve_at_limit;
    logic winner;

    assign starve_at_limit = (starve_cnt_reg == LIMIT);
    assign winner          = data_req & ~(inst_req & starve_at_limit);

    // Unqualified (pre-reset-gating) handshake results for this cycle.
    logic        mem_req_c;
    logic [70:0] mem_req_bus_c;
    logic        grant_c;
    logic        grant_idx_c;
    logic        resp_c;

    // Next-state, grant and response decode for the transaction FSM.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        starve_cnt_next = starve_cnt_reg;
        mem_req_c       = 1'b0;
        mem_req_bus_c   = '0;
        grant_c         = 1'b0;
        grant_idx_c     = owner_reg;
        resp_c          = 1'b0;

        case (state_reg)
            IDLE: begin
                mem_req_c   = |req_vec;
                grant_idx_c = winner;
                if (mem_req_c) begin
                    mem_req_bus_c = req_bus_arr[winner];
                    // Owner is latched even when not yet accepted so the
                    // grant cannot move while we wait in ADDR.
                    owner_next    = winner;
                    if (mem_addr_ok) begin
                        grant_c    = 1'b1;
                        state_next = DATA;
                    end else begin
                        state_next = ADDR;
                    end
                end
            end

            ADDR: begin
                // A requester dropping its valid here does not cancel; the
                // downstream has already seen the request.
                mem_req_c     = 1'b1;
                mem_req_bus_c = req_bus_arr[owner_reg];
                grant_idx_c   = owner_reg;
                if (mem_addr_ok) begin
                    grant_c    = 1'b1;
                    state_next = DATA;
                end
            end

            DATA: begin
                // Returning to IDLE here means the next request can only be
                // issued on the following cycle.
                if (mem_data_ok) begin
                    resp_c     = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Fairness bookkeeping happens only on accepted requests.
        if (grant_c) begin
            if (grant_idx_c == 1'b0) begin
                starve_cnt_next = '0;
            end else if (inst_req && !starve_at_limit) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end
    end

    // State, owner and starvation counter; reset acts without a clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Per-requester handshake steering; everything is forced low in reset.
    logic [NREQ-1:0] addr_ok_vec;
    logic [NREQ-1:0] data_ok_vec;
    logic [31:0]     rdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_ok_vec[gi] = resetn & grant_c & (grant_idx_c == 1'(gi));
            assign data_ok_vec[gi] = resetn & resp_c  & (owner_reg   == 1'(gi));
            assign rdata_arr[gi]   = data_ok_vec[gi] ? mem_rdata : 32'd0;
        end
    endgenerate

    assign inst_addr_ok = addr_ok_vec[0];
    assign inst_data_ok = data_ok_vec[0];
    assign inst_rdata   = rdata_arr[0];
    assign data_addr_ok = addr_ok_vec[1];
    assign data_data_ok = data_ok_vec[1];
    assign data_rdata   = rdata_arr[1];

    assign mem_req      = resetn & mem_req_c;
    assign mem_req_bus  = resetn ? mem_req_bus_c : 71'd0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: a behavioural downstream slave with
// programmable address/data latency, expected grants and responses queued
// when stimulus is applied, and a negedge monitor that pops and compares.

module tb_mem_req_arbiter;

    localparam int          STARVE_LIMIT = 4;
    localparam logic [31:0] RD_KEY       = 32'hC3A5_0F0F;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [70:0] inst_req_bus;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [70:0] data_req_bus;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic [70:0] mem_req_bus;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    mem_req_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_req_bus (inst_req_bus),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_req_bus (data_req_bus),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_req_bus  (mem_req_bus),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          is_data;
        logic [70:0] bus;
    } grant_t;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
    } resp_t;

    grant_t exp_grant[$];
    resp_t  exp_resp[$];

    function automatic logic [70:0] mk_bus(input bit wr, input logic [1:0] size, input logic [3:0] wstrb,
                                           input logic [31:0] addr, input logic [31:0] wdata);
        return {wr, size, wstrb, addr, wdata};
    endfunction

    task automatic exp_txn(input bit is_data, input logic [70:0] bus, input bit has_resp,
                           input logic [31:0] rdata);
        exp_grant.push_back('{is_data, bus});
        if (has_resp) exp_resp.push_back('{is_data, rdata});
    endtask

    // Downstream slave model; drives at posedge+2 after the main process.
    bit          slave_en  = 1'b1;
    int          addr_lat  = 0;
    int          data_lat  = 0;
    bit          rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr    = 32'd0;
    int          s_state   = 0;
    int          s_cnt     = 0;
    logic [31:0] s_addr    = 32'd0;

    initial begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (!slave_en) begin
                s_state = 0;
                s_cnt   = 0;
                continue;
            end
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            mem_rdata   = 32'd0;
            if (s_state == 0) begin
                if (mem_req) begin
                    if (s_cnt >= addr_lat) begin
                        mem_addr_ok = 1'b1;
                        s_addr      = mem_req_bus[63:32];
                        s_cnt       = 0;
                        s_state     = 1;
                    end else begin
                        s_cnt++;
                    end
                end
            end else begin
                if (s_cnt >= data_lat) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = rd_ovr_en ? rd_ovr : (s_addr ^ RD_KEY);
                    s_cnt       = 0;
                    s_state     = 0;
                end else begin
                    s_cnt++;
                end
            end
        end
    end

    // Monitor: every handshake is matched against the scoreboard queues.
    grant_t mon_g;
    resp_t  mon_r;

    always @(negedge clk) begin
        if (resetn) begin
            if (inst_addr_ok || data_addr_ok) begin
                check_val("addr_ok_onehot", {inst_addr_ok & data_addr_ok}, 0);
                if (exp_grant.size() == 0) begin
                    check_val("grant_unexpected", 1, 0);
                end else begin
                    mon_g = exp_grant.pop_front();
                    check_val("grant_owner", data_addr_ok, mon_g.is_data);
                    check_val("grant_bus", mem_req_bus, mon_g.bus);
                end
            end
            if (inst_data_ok || data_data_ok) begin
                check_val("data_ok_onehot", {inst_data_ok & data_data_ok}, 0);
                if (exp_resp.size() == 0) begin
                    check_val("resp_unexpected", 1, 0);
                end else begin
                    mon_r = exp_resp.pop_front();
                    check_val("resp_owner", data_data_ok, mon_r.is_data);
                    check_val("resp_rdata", data_data_ok ? data_rdata : inst_rdata, mon_r.rdata);
                    check_val("resp_other_rdata", data_data_ok ? inst_rdata : data_rdata, 0);
                end
            end
            if (!mem_req) check_val("noreq_bus_zero", mem_req_bus, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        resetn   = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_grant.size() != 0 || exp_resp.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check_val({tag, "_drain"}, exp_grant.size() + exp_resp.size(), 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        int n;

        resetn       = 1'b0;
        inst_req     = 1'b1;
        data_req     = 1'b1;
        inst_req_bus = mk_bus(1'b0, 2'd2, 4'hF, 32'h0000_0100, 32'd0);
        data_req_bus = mk_bus(1'b1, 2'd2, 4'hF, 32'h0000_0200, 32'h5555_AAAA);

        // Reset: outputs stay low even with both requesters active.
        #3;
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_bus", mem_req_bus, 0);
        check_val("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        check_val("rst_data_ok", {inst_data_ok, data_data_ok, inst_rdata, data_rdata}, 0);
        tick();
        inst_req = 1'b0;
        data_req = 1'b0;
        tick();
        resetn = 1'b1;

        // Both request with starve_cnt=0 and immediate accept: data wins.
        tick();
        addr_lat     = 0;
        data_lat     = 0;
        inst_req_bus = mk_bus(1'b0, 2'd2, 4'hF, 32'h0000_2000, 32'd0);
        data_req_bus = mk_bus(1'b1, 2'd2, 4'hF, 32'h0000_3000, 32'h1234_5678);
        exp_txn(1'b1, data_req_bus, 1'b1, 32'h0000_3000 ^ RD_KEY);
        inst_req = 1'b1;
        data_req = 1'b1;
        @(negedge clk);
        check_val("t1_data_addr_ok", data_addr_ok, 1);
        check_val("t1_inst_addr_ok", inst_addr_ok, 0);
        check_val("t1_bus", mem_req_bus, data_req_bus);
        tick();
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        check_val("t1_data_state_mem_req", mem_req, 0);
        wait_drain("t1");

        // Delayed accept: request and bus held steady for 4 cycles.
        do_reset();
        addr_lat     = 3;
        data_lat     = 1;
        rd_ovr_en    = 1'b1;
        rd_ovr       = 32'hDEAD_BEEF;
        data_req_bus = mk_bus(1'b0, 2'd2, 4'hF, 32'h0000_1000, 32'd0);
        exp_txn(1'b1, data_req_bus, 1'b1, 32'hDEAD_BEEF);
        tick();
        data_req = 1'b1;
        held = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) begin
                held++;
                check_val("t2_bus_stable", mem_req_bus, data_req_bus);
            end
            if (data_addr_ok) break;
            tick();
        end
        tick();
        data_req = 1'b0;
        check_val("t2_req_cycles", held, 4);
        wait_drain("t2");
        rd_ovr_en = 1'b0;

        // Starvation: both held high, grants D,D,D,D,I repeating.
        do_reset();
        addr_lat     = 0;
        data_lat     = 0;
        inst_req_bus = mk_bus(1'b0, 2'd2, 4'hF, 32'h0000_4000, 32'd0);
        data_req_bus = mk_bus(1'b0, 2'd1, 4'h3, 32'h0000_5000, 32'd0);
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) exp_txn(1'b0, inst_req_bus, 1'b1, 32'h0000_4000 ^ RD_KEY);
            else              exp_txn(1'b1, data_req_bus, 1'b1, 32'h0000_5000 ^ RD_KEY);
        end
        tick();
        inst_req = 1'b1;
        data_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (exp_grant.size() != 0 && n < 60);
        inst_req = 1'b0;
        data_req = 1'b0;
        check_val("t3_grants_left", exp_grant.size(), 0);
        wait_drain("t3");

        // Inst in ADDR: data arriving and inst withdrawing change nothing.
        do_reset();
        addr_lat     = 3;
        data_lat     = 0;
        inst_req_bus = mk_bus(1'b0, 2'd2, 4'hF, 32'h0000_6000, 32'd0);
        data_req_bus = mk_bus(1'b1, 2'd1, 4'h3, 32'h0000_7000, 32'hAAAA_5555);
        exp_txn(1'b0, inst_req_bus, 1'b1, 32'h0000_6000 ^ RD_KEY);
        exp_txn(1'b1, data_req_bus, 1'b1, 32'h0000_7000 ^ RD_KEY);
        tick();
        inst_req = 1'b1;
        @(negedge clk);
        check_val("t4_idle_bus", mem_req_bus, inst_req_bus);
        tick();
        data_req = 1'b1;
        @(negedge clk);
        check_val("t4_addr_hold1", mem_req_bus, inst_req_bus);
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        check_val("t4_addr_hold2", mem_req_bus, inst_req_bus);
        check_val("t4_addr_mem_req", mem_req, 1);
        tick();
        @(negedge clk);
        check_val("t4_inst_accept", inst_addr_ok, 1);
        check_val("t4_data_not_granted", data_addr_ok, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (exp_grant.size() != 0 && n < 40);
        data_req = 1'b0;
        wait_drain("t4");

        // Stray mem_data_ok in IDLE is ignored.
        do_reset();
        tick();
        slave_en    = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1111_1111;
        @(negedge clk);
        check_val("t5_idle_dataok_ign", {inst_data_ok, data_data_ok}, 0);
        check_val("t5_idle_rdata", {inst_rdata, data_rdata}, 0);

        // Accept a data request, then abandon it with an async reset pulse.
        tick();
        mem_data_ok  = 1'b0;
        mem_rdata    = 32'd0;
        data_req_bus = mk_bus(1'b0, 2'd2, 4'hF, 32'h0000_8000, 32'd0);
        exp_txn(1'b1, data_req_bus, 1'b0, 32'd0);
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        check_val("t5_accept", data_addr_ok, 1);
        tick();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_val("t5_rst_outputs", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        #1;
        resetn = 1'b1;
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h2222_2222;
        @(negedge clk);
        check_val("t5_stale_dataok", {inst_data_ok, data_data_ok}, 0);
        check_val("t5_stale_rdata", {inst_rdata, data_rdata}, 0);

        // Normal issue from IDLE after the abandoned transaction.
        tick();
        mem_data_ok  = 1'b0;
        mem_rdata    = 32'd0;
        slave_en     = 1'b1;
        addr_lat     = 0;
        data_lat     = 0;
        inst_req_bus = mk_bus(1'b0, 2'd2, 4'hF, 32'h0000_9000, 32'd0);
        exp_txn(1'b0, inst_req_bus, 1'b1, 32'h0000_9000 ^ RD_KEY);
        inst_req = 1'b1;
        @(negedge clk);
        check_val("t5_reissue", inst_addr_ok, 1);
        tick();
        inst_req = 1'b0;
        wait_drain("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while an inst request waits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 inst_req  in  1  instruction requester request valid.
REQ-005 inst_req_bus  in  71  {wr[70], size[69:68], wstrb[67:64], addr[63:32], wdata[31:0]}.
REQ-006 inst_addr_ok  out  1  inst request accepted downstream.
REQ-007 inst_data_ok  out  1  inst response returned.
REQ-008 inst_rdata  out  32  inst read data, valid with inst_data_ok.
REQ-009 data_req  in  1  data requester (exe stage) request valid.
REQ-010 data_req_bus  in  71  same layout as inst_req_bus.
REQ-011 data_addr_ok  out  1  data request accepted downstream.
REQ-012 data_data_ok  out  1  data response returned.
REQ-013 data_rdata  out  32  data read data, valid with data_data_ok.
REQ-014 mem_req  out  1  shared downstream request valid.
REQ-015 mem_req_bus  out  71  winning requester's bus, same layout.
REQ-016 mem_addr_ok  in  1  downstream accepts request this cycle.
REQ-017 mem_data_ok  in  1  downstream response this cycle.
REQ-018 mem_rdata  in  32  downstream read data.

Function
REQ-019 The block SHALL implement states IDLE, ADDR, DATA; exactly one downstream transaction outstanding at any time.
REQ-020 In IDLE, winner = inst if (inst_req & starve_cnt==STARVE_LIMIT) or ~data_req; else data when data_req; mem_req = inst_req|data_req, combinational same cycle.
REQ-021 In IDLE with mem_req & mem_addr_ok: assert winner's addr_ok that cycle, register owner, go to DATA.
REQ-022 In IDLE with mem_req & ~mem_addr_ok: register winner as owner, go to ADDR; grant SHALL NOT change until accepted.
REQ-023 In ADDR: mem_req=1, mem_req_bus = owner's bus; on mem_addr_ok assert owner's addr_ok, go to DATA.
REQ-024 In DATA: mem_req=0; both addr_ok outputs 0; on mem_data_ok assert owner's data_ok with rdata=mem_rdata, go to IDLE.
REQ-025 No new request SHALL be issued in the cycle the response returns; next issue earliest the following cycle (min 2 cycles per transaction).
REQ-026 addr_ok/data_ok SHALL never be asserted to the non-owner; non-owner rdata SHALL be 0.
REQ-027 mem_data_ok in IDLE or ADDR SHALL be ignored (no output asserted).
REQ-028 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, when data is accepted while inst_req=1; clear to 0 when inst is accepted; otherwise hold.
REQ-029 mem_req_bus SHALL equal the winner's bus in IDLE, owner's bus in ADDR, and all zeros in DATA or when mem_req=0.
REQ-030 Requester withdrawing req in ADDR SHALL NOT cancel the transaction; owner's bus is forwarded as presented.

Reset
REQ-031 resetn=0 SHALL immediately force state IDLE, owner=inst, starve_cnt=0, regardless of clock.
REQ-032 During reset all outputs SHALL be 0; an outstanding transaction is abandoned and its later mem_data_ok ignored per REQ-027.

Verification
REQ-033 Both req=1 at IDLE, starve_cnt=0, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_req_bus=data_req_bus, state DATA.
REQ-034 data read addr 0x1000, mem_addr_ok delayed 3 cycles, mem_data_ok 2 cycles later with 0xDEADBEEF -> mem_req held 4 cycles, bus stable, data_data_ok=1 with data_rdata=0xDEADBEEF.
REQ-035 inst_req and data_req held high, immediate addr_ok/data_ok -> grants D,D,D,D,I,D,D,D,D,I (STARVE_LIMIT=4).
REQ-036 In ADDR owned by inst, data_req rises -> mem_req_bus stays inst bus until mem_addr_ok; data granted next IDLE.
REQ-037 resetn low mid-DATA, then high, then mem_data_ok=1 -> no data_ok asserted; next request issues normally from IDLE.
